// File: rtl/servo_pkg.sv
// Shared definitions for the servo slew scheduler: position/step widths,
// scheduler state encoding and the command position clamp.
package servo_pkg;

    localparam int POS_W  = 10;
    localparam int STEP_W = 4;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_e;

    // Saturate an incoming command position into the legal servo travel.
    function automatic logic [POS_W-1:0] clamp_pos(
        input logic [POS_W-1:0] p,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi
    );
        if (p < lo) begin
            return lo;
        end
        if (p > hi) begin
            return hi;
        end
        return p;
    endfunction

endpackage

// File: rtl/servo_slew_sched_if.sv
// Command port of the servo slew scheduler: valid/ready transfer of
// channel, target position and slew step, plus the bad-channel error pulse.
interface servo_slew_sched_if #(
    parameter int CH_W = 2
);
    import servo_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CH_W-1:0]   cmd_ch;
    logic [POS_W-1:0]  cmd_pos;
    logic [STEP_W-1:0] cmd_step;
    logic              cmd_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_pos, cmd_step,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_pos, cmd_step,
        output cmd_ready, cmd_err
    );

endinterface

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; frame_tick marks the last cycle of every
// FRAME_CYC-cycle frame (one PWM period).
module servo_frame_timer #(
    parameter int FRAME_CYC = 1048576
) (
    input  logic clk,
    input  logic clr,
    output logic frame_tick
);

    localparam int CNT_W = (FRAME_CYC > 2) ? $clog2(FRAME_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last     = (r_cnt == CNT_LAST);
    assign frame_tick = w_last;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_slew_sched.sv
// Multi-channel servo command scheduler: stores per-channel target and slew
// step, and once per frame sweeps all channels through one shared slew adder.
module servo_slew_sched
    import servo_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int FRAME_CYC = 1048576,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = 1023,
    parameter int POS_RST   = 512
) (
    input  logic                    clk,
    input  logic                    clr,
    servo_slew_sched_if.slave       cmd,
    output logic [NUM_CH*POS_W-1:0] pos_out,
    output logic [NUM_CH-1:0]       busy,
    output logic                    frame_tick
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [0:0]        ST_IDLE   = S_IDLE;
    localparam logic [0:0]        ST_UPDATE = S_UPDATE;
    localparam logic [CH_W-1:0]   IDX_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [POS_W-1:0]  P_LO      = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0]  P_HI      = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]  P_RST     = POS_W'(POS_RST);

    logic [POS_W-1:0]  r_cur  [NUM_CH];
    logic [POS_W-1:0]  r_tgt  [NUM_CH];
    logic [STEP_W-1:0] r_step [NUM_CH];
    logic [NUM_CH-1:0] r_busy;
    logic              r_err;
    logic [0:0]        r_state;
    logic [CH_W-1:0]   r_idx;

    logic              w_xfer;
    logic              w_bad;
    logic              w_wr;
    logic [POS_W-1:0]  w_clamped;
    logic [POS_W-1:0]  w_cur_sel;
    logic [POS_W-1:0]  w_tgt_sel;
    logic [STEP_W-1:0] w_step_sel;
    logic [POS_W-1:0]  w_next;

    // Move cur toward tgt by at most step, saturating on tgt so it never overshoots.
    function automatic logic [POS_W-1:0] slew_next(
        input logic [POS_W-1:0]  cur,
        input logic [POS_W-1:0]  tgt,
        input logic [STEP_W-1:0] step
    );
        logic signed [POS_W+1:0] s_cur;
        logic signed [POS_W+1:0] s_tgt;
        logic signed [POS_W+1:0] s_stp;
        logic signed [POS_W+1:0] s_up;
        logic signed [POS_W+1:0] s_dn;
        s_cur = signed'({2'b00, cur});
        s_tgt = signed'({2'b00, tgt});
        s_stp = signed'({{(POS_W+2-STEP_W){1'b0}}, step});
        s_up  = s_cur + s_stp;
        s_dn  = s_cur - s_stp;
        if (step == '0) begin
            return tgt;
        end
        if (s_cur < s_tgt) begin
            return (s_up > s_tgt) ? tgt : s_up[POS_W-1:0];
        end
        if (s_cur > s_tgt) begin
            return (s_dn < s_tgt) ? tgt : s_dn[POS_W-1:0];
        end
        return cur;
    endfunction

    servo_frame_timer #(
        .FRAME_CYC (FRAME_CYC)
    ) u_timer (
        .clk        (clk),
        .clr        (clr),
        .frame_tick (frame_tick)
    );

    // Only channel codes that can exceed NUM_CH need a range check.
    generate
        if ((1 << CH_W) > NUM_CH) begin : g_chk
            assign w_bad = (cmd.cmd_ch >= CH_W'(NUM_CH));
        end else begin : g_nochk
            assign w_bad = 1'b0;
        end
    endgenerate

    assign cmd.cmd_ready = (r_state == ST_IDLE);
    assign cmd.cmd_err   = r_err;
    assign w_xfer        = cmd.cmd_valid & cmd.cmd_ready;
    assign w_wr          = w_xfer & ~w_bad;
    assign w_clamped     = clamp_pos(cmd.cmd_pos, P_LO, P_HI);

    assign w_cur_sel  = r_cur[r_idx];
    assign w_tgt_sel  = r_tgt[r_idx];
    assign w_step_sel = r_step[r_idx];
    assign w_next     = slew_next(w_cur_sel, w_tgt_sel, w_step_sel);

    assign busy = r_busy;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_pos
            assign pos_out[k*POS_W +: POS_W] = r_cur[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_busy  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_cur[k]  <= P_RST;
                r_tgt[k]  <= P_RST;
                r_step[k] <= '0;
            end
        end else begin
            r_err <= w_xfer & w_bad;
            if (r_state == ST_IDLE) begin
                if (w_wr) begin
                    r_tgt[cmd.cmd_ch]  <= w_clamped;
                    r_step[cmd.cmd_ch] <= cmd.cmd_step;
                    if (cmd.cmd_step == '0) begin
                        r_cur[cmd.cmd_ch]  <= w_clamped;
                        r_busy[cmd.cmd_ch] <= 1'b0;
                    end else begin
                        r_busy[cmd.cmd_ch] <= (w_clamped != r_cur[cmd.cmd_ch]);
                    end
                end
                if (frame_tick) begin
                    r_state <= ST_UPDATE;
                    r_idx   <= '0;
                end
            end else begin
                // One channel per cycle through the shared slew adder.
                r_cur[r_idx]  <= w_next;
                r_busy[r_idx] <= (w_next != w_tgt_sel);
                if (r_idx == IDX_LAST) begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end else begin
                    r_idx <= r_idx + CH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_slew_sched.sv
// Directed bench for servo_slew_sched: a 4-channel full-range instance and a
// 3-channel clamped instance (POS 100..900) sharing clock and reset.
module tb_servo_slew_sched;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [39:0] pos;
    logic [3:0]  busy;
    logic        tick;
    logic [29:0] pos_b;
    logic [2:0]  busy_b;
    logic        tick_b;
    int          errors = 0;
    int          checks = 0;

    servo_slew_sched_if #(.CH_W(2)) bus   ();
    servo_slew_sched_if #(.CH_W(2)) bus_b ();

    servo_slew_sched #(
        .NUM_CH (4), .FRAME_CYC (16), .POS_MIN (0), .POS_MAX (1023), .POS_RST (512)
    ) dut (
        .clk (clk), .clr (clr), .cmd (bus), .pos_out (pos), .busy (busy), .frame_tick (tick)
    );

    servo_slew_sched #(
        .NUM_CH (3), .FRAME_CYC (16), .POS_MIN (100), .POS_MAX (900), .POS_RST (512)
    ) dut_b (
        .clk (clk), .clr (clr), .cmd (bus_b), .pos_out (pos_b), .busy (busy_b), .frame_tick (tick_b)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] chp(input int k);
        return pos[k*10 +: 10];
    endfunction

    function automatic logic [9:0] chp_b(input int k);
        return pos_b[k*10 +: 10];
    endfunction

    task automatic send(input int ch, input int p, input int st);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = 2'(ch);
        bus.cmd_pos   = 10'(p);
        bus.cmd_step  = 4'(st);
        for (int i = 0; i < 40 && !bus.cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic send_b(input int ch, input int p, input int st);
        @(negedge clk);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_ch    = 2'(ch);
        bus_b.cmd_pos   = 10'(p);
        bus_b.cmd_step  = 4'(st);
        for (int i = 0; i < 40 && !bus_b.cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 bus_b.cmd_valid = 1'b0;
    endtask

    // Leaves the caller at the negedge of the tick cycle when ok=1.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic sync_frame(output bit ok);
        wait_tick(ok);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (chp(k) !== 10'd512) begin
                errors++;
                $display("FAIL reset_pos ch%0d got=%0d want=512", k, chp(k));
            end
        end
        checks++;
        if (busy !== 4'b0 || bus.cmd_ready !== 1'b1 || bus.cmd_err !== 1'b0 || tick !== 1'b0 || tick_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b rdy=%b err=%b tick=%b want busy=0000 rdy=1 err=0 tick=0",
                     busy, bus.cmd_ready, bus.cmd_err, tick);
        end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tick) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL reset_first_tick got cycle=%0d want=15", n);
        end
    endtask

    task automatic test_jump;
        send(1, 600, 0);
        @(negedge clk);
        checks++;
        if (chp(1) !== 10'd600 || busy[1] !== 1'b0 || bus.cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL jump_ch1 got pos=%0d busy=%b err=%b want pos=600 busy=0 err=0",
                     chp(1), busy[1], bus.cmd_err);
        end
    endtask

    task automatic test_slew;
        bit ok;
        logic [9:0] exp_p [4] = '{10'd515, 10'd518, 10'd520, 10'd520};
        logic       exp_b [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        sync_frame(ok);
        send(2, 520, 3);
        @(negedge clk);
        checks++;
        if (chp(2) !== 10'd512 || busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL slew_accept got pos=%0d busy=%b want pos=512 busy=1", chp(2), busy[2]);
        end
        for (int f = 0; f < 4; f++) begin
            wait_tick(ok);
            repeat (4) @(negedge clk);
            checks++;
            if (!ok || chp(2) !== exp_p[f] || busy[2] !== exp_b[f]) begin
                errors++;
                $display("FAIL slew_frame%0d got pos=%0d busy=%b tick_seen=%b want pos=%0d busy=%b",
                         f, chp(2), busy[2], ok, exp_p[f], exp_b[f]);
            end
        end
    endtask

    task automatic test_no_wrap;
        bit ok;
        sync_frame(ok);
        send(0, 1020, 0);
        send(3, 5, 0);
        send(0, 1023, 5);
        send(3, 2, 7);
        @(negedge clk);
        checks++;
        if (chp(0) !== 10'd1020 || chp(3) !== 10'd5 || busy !== 4'b1001) begin
            errors++;
            $display("FAIL nowrap_setup got ch0=%0d ch3=%0d busy=%b want ch0=1020 ch3=5 busy=1001",
                     chp(0), chp(3), busy);
        end
        wait_tick(ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || chp(0) !== 10'd1023 || chp(3) !== 10'd2 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL nowrap_land got ch0=%0d ch3=%0d busy=%b want ch0=1023 ch3=2 busy=0000",
                     chp(0), chp(3), busy);
        end
        checks++;
        if (chp(1) !== 10'd600 || chp(2) !== 10'd520) begin
            errors++;
            $display("FAIL nowrap_others got ch1=%0d ch2=%0d want ch1=600 ch2=520", chp(1), chp(2));
        end
    endtask

    task automatic test_clamp;
        send_b(0, 50, 0);
        @(negedge clk);
        checks++;
        if (chp_b(0) !== 10'd100 || busy_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL clamp_low got pos=%0d busy=%b want pos=100 busy=0", chp_b(0), busy_b[0]);
        end
        send_b(1, 1000, 0);
        @(negedge clk);
        checks++;
        if (chp_b(1) !== 10'd900 || busy_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL clamp_high got pos=%0d busy=%b want pos=900 busy=0", chp_b(1), busy_b[1]);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int zeros;
        sync_frame(ok);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = 2'd1;
        bus.cmd_pos   = 10'd600;
        bus.cmd_step  = 4'd0;
        wait_tick(ok);
        checks++;
        if (!ok || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tick_ready got rdy=%b tick_seen=%b want rdy=1", bus.cmd_ready, ok);
        end
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b0) zeros++;
        end
        @(negedge clk);
        checks++;
        if (zeros != 4 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_gap got low_cycles=%0d rdy_after=%b want low_cycles=4 rdy_after=1",
                     zeros, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (chp(1) !== 10'd600) begin
            errors++;
            $display("FAIL b2b_hold got ch1=%0d want 600", chp(1));
        end
    endtask

    task automatic test_bad_channel;
        send_b(3, 300, 0);
        @(negedge clk);
        checks++;
        if (bus_b.cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_ch_err got err=%b want 1", bus_b.cmd_err);
        end
        checks++;
        if (chp_b(0) !== 10'd100 || chp_b(1) !== 10'd900 || chp_b(2) !== 10'd512 || busy_b !== 3'b000) begin
            errors++;
            $display("FAIL bad_ch_state got ch0=%0d ch1=%0d ch2=%0d busy=%b want 100 900 512 000",
                     chp_b(0), chp_b(1), chp_b(2), busy_b);
        end
        @(negedge clk);
        checks++;
        if (bus_b.cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_ch_pulse got err=%b want 0", bus_b.cmd_err);
        end
    endtask

    task automatic test_clr_mid_update;
        bit ok;
        send(2, 100, 1);
        wait_tick(ok);
        @(negedge clk);
        checks++;
        if (!ok || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_update got rdy=%b tick_seen=%b want rdy=0", bus.cmd_ready, ok);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (chp(k) !== 10'd512) begin
                errors++;
                $display("FAIL clr_pos ch%0d got=%0d want=512", k, chp(k));
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 4'b0 || bus.cmd_ready !== 1'b1 || chp(2) !== 10'd512) begin
            errors++;
            $display("FAIL clr_ctrl got busy=%b rdy=%b ch2=%0d want busy=0000 rdy=1 ch2=512",
                     busy, bus.cmd_ready, chp(2));
        end
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_ch      = '0;
        bus.cmd_pos     = '0;
        bus.cmd_step    = '0;
        bus_b.cmd_valid = 1'b0;
        bus_b.cmd_ch    = '0;
        bus_b.cmd_pos   = '0;
        bus_b.cmd_step  = '0;
        test_reset();
        test_jump();
        test_slew();
        test_no_wrap();
        test_clamp();
        test_back_to_back();
        test_bad_channel();
        test_clr_mid_update();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
